frame_register_snapshot: RTL and testbench
==========================================

Name: frame_register_snapshot

Overview:
- Frame-synchronous fetch controller between the processor register file and the VGA display path.
- Once per frame, at screen end, it reads the 15 game registers through one shared register-file read port using a req/grant handshake.
- It stages the 15 values and commits them to the display in a single cycle, so one frame never mixes values from two game ticks.
- It also derives the game_underway mode flag from the committed values.

Parameters:
- NUM_REGS, 15, registers fetched per frame.
- BASE_ADDR, 5'd1, register-file address of snapshot index 0; index i is at BASE_ADDR+i.
- TIMEOUT, 16, maximum cycles to wait for rd_grant on one word before the frame is aborted.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-low reset.
- screen_end  in  1  one-clk-cycle pulse at the frame boundary, already synchronized to clk.
- rd_req  out  1  read request to the shared register-file port.
- rd_addr  out  5  register address; valid while rd_req=1.
- rd_grant  in  1  port granted; rd_data is valid in the same cycle.
- rd_data  in  32  register-file read data.
- snapshot  out  NUM_REGS*32  committed values; index i occupies bits [32i+31:32i].
- frame_valid  out  1  high after the first successful commit.
- game_underway  out  1  OR of (snapshot[i] != 0) for i = 0..13; index 14 (high score) is excluded.
- busy  out  1  fetch in progress.
- abort  out  1  one-cycle pulse when a frame fetch times out.
- overrun_count  out  8  saturating count of screen_end pulses ignored while busy.

Behaviour:
- Snapshot index map:
  - 0-3: pipe1..4 x
  - 4-7: pipe1..4 bottom-pipe top
  - 8-11: pipe1..4 y gap
  - 12: bird top
  - 13: current score
  - 14: high score
- Reset (reset=0, async): every output is 0 (snapshot all zero, frame_valid=0, game_underway=0, overrun_count=0). Staging is cleared, the FSM goes to IDLE and idx=0. Asserting reset mid-fetch discards the fetch immediately.
- IDLE:
  - busy=0, rd_req=0.
  - On screen_end=1: idx<=0, wait counter<=0, go to FETCH.
- FETCH:
  - busy=1, rd_req=1, rd_addr=BASE_ADDR+idx (5-bit wrap).
  - If rd_grant=1: staging[idx]<=rd_data, wait<=0. If idx==NUM_REGS-1, go to COMMIT; otherwise idx<=idx+1 and rd_req stays high the next cycle.
  - If rd_grant=0: wait<=wait+1. If wait reaches TIMEOUT-1 without a grant, go to IDLE, pulse abort for one cycle, and leave snapshot unchanged.
  - With a continuous grant, the fetch takes exactly NUM_REGS cycles.
- COMMIT (one cycle):
  - busy=1, rd_req=0.
  - snapshot<=staging, frame_valid<=1.
  - game_underway is updated from the new staging in the same edge (registered; consistent with snapshot).
  - Next state IDLE.
  - Latency: snapshot changes on the edge that ends COMMIT, NUM_REGS+1 cycles after the screen_end cycle when grants are continuous.
- Overrun: a screen_end while busy=1 (FETCH or COMMIT) does not restart the fetch. overrun_count increments and saturates at 255. A screen_end in the same cycle the FSM enters IDLE counts as IDLE-entry only; it is not accepted.
- rd_req drops in the same cycle the FSM leaves FETCH. rd_data is ignored whenever rd_grant=0.
- snapshot is never partially updated; all words change in a single edge.
- abort and overrun do not touch frame_valid or game_underway.

Test Plan:
1. Release reset, pulse screen_end, hold rd_grant=1 with rd_data=addr*3 -> rd_addr goes 1..15 on consecutive cycles, busy for 16 cycles. snapshot[i]=(i+1)*3, frame_valid=1, game_underway=1.
2. All rd_data=0 except index 14=99 -> after commit game_underway=0, snapshot[14]=99.
3. Grant alternating 1/0 -> fetch completes in 29 cycles with correct values; no abort.
4. Hold rd_grant=0 for 16 cycles at idx=5 -> abort pulses once, FSM returns to IDLE, prior snapshot unchanged, rd_req=0.
5. Pulse screen_end 4 times during one fetch -> overrun_count=4. Pulse 300 times across busy windows -> overrun_count=255.
6. Assert reset at idx=7 -> all outputs 0 asynchronously. After release, the next screen_end fetch starts at rd_addr=1.

Source files
------------

// File: rtl/frame_register_snapshot.sv
// Once per frame, fetch the game registers over the shared register-file read
// port into a staging buffer, then commit them to the display in a single edge.
module frame_register_snapshot #(
  parameter int         NUM_REGS  = 15,
  parameter logic [4:0] BASE_ADDR = 5'd1,
  parameter int         TIMEOUT   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     screen_end,
  output logic                     rd_req,
  output logic [4:0]               rd_addr,
  input  logic                     rd_grant,
  input  logic [31:0]              rd_data,
  output logic [NUM_REGS*32-1:0]   snapshot,
  output logic                     frame_valid,
  output logic                     game_underway,
  output logic                     busy,
  output logic                     abort,
  output logic [7:0]               overrun_count
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_COMMIT} state_t;

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [WAIT_W-1:0]   r_wait;
  logic [31:0]         r_stage [NUM_REGS];
  logic                w_last, w_timeout, w_underway;

  assign w_last    = (r_idx == IDX_W'(NUM_REGS - 1));
  assign w_timeout = (r_wait == WAIT_W'(TIMEOUT - 1));
  assign rd_addr   = rd_req ? (BASE_ADDR + 5'(r_idx)) : 5'd0;

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    rd_req      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (screen_end) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        busy   = 1'b1;
        rd_req = 1'b1;
        if (rd_grant && w_last)        w_state_nxt = S_COMMIT;
        else if (!rd_grant && w_timeout) w_state_nxt = S_IDLE;
      end
      S_COMMIT: begin
        busy        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The high-score word (last index) does not indicate a game in progress.
  always_comb begin
    w_underway = 1'b0;
    for (int i = 0; i < NUM_REGS - 1; i++)
      w_underway = w_underway | (r_stage[i] != 32'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_wait        <= '0;
      abort         <= 1'b0;
      overrun_count <= 8'd0;
      frame_valid   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      abort   <= (r_state == S_FETCH) && !rd_grant && w_timeout;
      if (busy && screen_end && overrun_count != 8'hFF)
        overrun_count <= overrun_count + 8'd1;
      case (r_state)
        S_IDLE: begin
          if (screen_end) begin
            r_idx  <= '0;
            r_wait <= '0;
          end
        end
        S_FETCH: begin
          if (rd_grant) begin
            r_wait <= '0;
            if (!w_last) r_idx <= r_idx + IDX_W'(1);
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_COMMIT: frame_valid <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_stage[i] <= 32'd0;
    end else if (r_state == S_FETCH && rd_grant) begin
      r_stage[r_idx] <= rd_data;
    end
  end

  // All words and the derived mode flag move together on the commit edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snapshot      <= '0;
      game_underway <= 1'b0;
    end else if (r_state == S_COMMIT) begin
      for (int i = 0; i < NUM_REGS; i++) snapshot[i*32 +: 32] <= r_stage[i];
      game_underway <= w_underway;
    end
  end

endmodule

// File: tb/tb_frame_register_snapshot.sv
// Directed bench for frame_register_snapshot: fetch, commit, timeout, overrun, reset.
module tb_frame_register_snapshot;

  logic          clk = 1'b0;
  logic          reset, screen_end, rd_req, rd_grant;
  logic [4:0]    rd_addr;
  logic [31:0]   rd_data;
  logic [479:0]  snapshot;
  logic          frame_valid, game_underway, busy, abort;
  logic [7:0]    overrun_count;

  int n_checks = 0;
  int n_errors = 0;
  int n_abort  = 0;
  int mode     = 0;

  always #5 clk = ~clk;

  frame_register_snapshot dut (
    .clk(clk), .reset(reset), .screen_end(screen_end),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant), .rd_data(rd_data),
    .snapshot(snapshot), .frame_valid(frame_valid), .game_underway(game_underway),
    .busy(busy), .abort(abort), .overrun_count(overrun_count)
  );

  // Register-file model; data is poisoned whenever the grant is low.
  always_comb begin
    rd_data = 32'hDEADBEEF;
    if (rd_grant) begin
      case (mode)
        0: rd_data = 32'(rd_addr) * 3;
        1: rd_data = (rd_addr == 5'd15) ? 32'd99 : 32'd0;
        2: rd_data = 32'(rd_addr) * 7;
        default: rd_data = 32'd0;
      endcase
    end
  end

  always @(posedge clk) if (abort) n_abort++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    screen_end = 1'b1;
    tick();
    screen_end = 1'b0;
  endtask

  function automatic logic [31:0] word(input int i);
    return snapshot[i*32 +: 32];
  endfunction

  task automatic pulse_pairs(input int n);
    for (int p = 0; p < n; p++) begin
      tick();
      screen_end = 1'b1;
      tick();
      screen_end = 1'b0;
    end
  endtask

  initial begin
    int n;
    int ab0;
    reset = 1'b0; screen_end = 1'b0; rd_grant = 1'b0;
    tick(); tick();
    chk("rst_snapshot", {31'd0, snapshot == '0}, 1);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_underway", game_underway, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_overrun", overrun_count, 0);
    reset = 1'b1;
    tick();

    // Test 1: continuous grant, data = addr*3
    mode = 0; rd_grant = 1'b1;
    start_frame();
    for (int k = 0; k < 15; k++) begin
      chk("t1_rd_req", rd_req, 1);
      chk("t1_rd_addr", rd_addr, k + 1);
      chk("t1_busy", busy, 1);
      tick();
    end
    chk("t1_commit_rd_req", rd_req, 0);
    chk("t1_commit_busy", busy, 1);
    chk("t1_commit_fv_pre", frame_valid, 0);
    chk("t1_commit_snap_pre", word(0), 0);
    tick();
    chk("t1_busy_done", busy, 0);
    for (int i = 0; i < 15; i++) chk("t1_word", word(i), (i + 1) * 3);
    chk("t1_frame_valid", frame_valid, 1);
    chk("t1_underway", game_underway, 1);

    // Test 2: only the high score is non-zero
    mode = 1;
    start_frame();
    repeat (15) tick();
    chk("t2_underway_hold", game_underway, 1);
    tick();
    chk("t2_underway", game_underway, 0);
    chk("t2_word14", word(14), 99);
    chk("t2_word13", word(13), 0);
    chk("t2_word0", word(0), 0);
    chk("t2_frame_valid", frame_valid, 1);

    // Test 3: alternating grant
    mode = 2; ab0 = n_abort;
    start_frame();
    n = 0;
    while (rd_req && n < 100) begin
      rd_grant = (n % 2 == 0);
      tick();
      n++;
    end
    rd_grant = 1'b1;
    chk("t3_fetch_cycles", n, 29);
    tick();
    for (int i = 0; i < 15; i++) chk("t3_word", word(i), (i + 1) * 7);
    chk("t3_no_abort", n_abort - ab0, 0);

    // Test 4: grant withheld at idx 5 until timeout
    ab0 = n_abort;
    start_frame();
    repeat (5) tick();
    chk("t4_rd_addr", rd_addr, 6);
    rd_grant = 1'b0;
    n = 0;
    while (rd_req && n < 100) begin
      tick();
      n++;
    end
    chk("t4_wait_cycles", n, 16);
    chk("t4_abort_hi", abort, 1);
    chk("t4_busy", busy, 0);
    chk("t4_rd_req", rd_req, 0);
    rd_grant = 1'b1;
    tick();
    chk("t4_abort_lo", abort, 0);
    chk("t4_abort_count", n_abort - ab0, 1);
    chk("t4_word0_kept", word(0), 7);
    chk("t4_word14_kept", word(14), 105);
    chk("t4_frame_valid", frame_valid, 1);
    chk("t4_underway", game_underway, 1);

    // Test 5: overrun counting and saturation
    start_frame();
    pulse_pairs(4);
    repeat (10) tick();
    chk("t5_busy", busy, 0);
    chk("t5_overrun4", overrun_count, 4);
    for (int f = 0; f < 38; f++) begin
      start_frame();
      pulse_pairs(8);
      tick(); tick();
      if (f == 0) chk("t5_overrun12", overrun_count, 12);
    end
    chk("t5_overrun_sat", overrun_count, 255);
    start_frame();
    pulse_pairs(2);
    repeat (14) tick();
    chk("t5_overrun_hold", overrun_count, 255);
    chk("t5_frame_valid", frame_valid, 1);

    // Test 6: asynchronous reset mid-fetch
    mode = 0;
    start_frame();
    repeat (7) tick();
    chk("t6_rd_addr", rd_addr, 8);
    #2 reset = 1'b0;
    #1;
    chk("t6_snapshot", {31'd0, snapshot == '0}, 1);
    chk("t6_rd_req", rd_req, 0);
    chk("t6_rd_addr0", rd_addr, 0);
    chk("t6_busy", busy, 0);
    chk("t6_frame_valid", frame_valid, 0);
    chk("t6_underway", game_underway, 0);
    chk("t6_overrun", overrun_count, 0);
    chk("t6_abort", abort, 0);
    tick();
    reset = 1'b1;
    tick();
    start_frame();
    chk("t6_restart_addr", rd_addr, 1);
    chk("t6_restart_req", rd_req, 1);
    repeat (16) tick();
    chk("t6_word14", word(14), 45);
    chk("t6_word0", word(0), 3);
    chk("t6_frame_valid2", frame_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
